// File: rtl/vga_pixel_feeder.sv
// Buffers the frame-buffer pixel stream in a small FIFO and hands one RGB word per
// active pixel to the VGA timing generator, realigning to frame starts after any error.
module vga_pixel_feeder #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int DEPTH = 16
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [23:0]              in_data,
  input  logic                     in_sof,
  input  logic                     frame_start,
  input  logic                     pix_req,
  output logic [23:0]              rgb_out,
  output logic                     underflow,
  output logic                     resync,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PIX_TOTAL = HDISP * VDISP;
  localparam int AW        = $clog2(DEPTH);
  localparam int LW        = AW + 1;
  localparam int CW        = $clog2(PIX_TOTAL + 1);

  typedef enum logic [1:0] {
    RESYNC     = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [24:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic [CW-1:0]   cnt_reg;
  logic [23:0]     rgb_reg, rgb_next;
  logic            underflow_reg;

  logic            push, pop, flush;
  logic            rgb_load, cnt_clr, cnt_inc, set_underflow;
  logic            full, empty;
  logic [24:0]     head;
  logic            head_sof;

  assign full     = (level_reg == LW'(DEPTH));
  assign empty    = (level_reg == '0);
  assign head     = mem[rd_ptr_reg];
  assign head_sof = head[24];

  always_comb begin
    state_next    = state_reg;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;
    rgb_load      = 1'b0;
    rgb_next      = '0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    set_underflow = 1'b0;
    in_ready      = 1'b1;

    case (state_reg)
      RESYNC: begin
        // FIFO is always empty here; only a start-of-frame word may enter.
        if (pix_req) rgb_load = 1'b1;
        if (in_valid && in_sof) begin
          push       = 1'b1;
          state_next = WAIT_FRAME;
        end
      end

      WAIT_FRAME: begin
        if (pix_req) rgb_load = 1'b1;
        if (frame_start) begin
          if (!empty && head_sof) begin
            state_next = RUN;
            cnt_clr    = 1'b1;
          end else begin
            state_next = RESYNC;
            flush      = 1'b1;
          end
        end
      end

      RUN: begin
        if (frame_start) begin
          // New frame before the current one finished: drop everything.
          if (pix_req) rgb_load = 1'b1;
          state_next = RESYNC;
          flush      = 1'b1;
        end else if (pix_req) begin
          rgb_load = 1'b1;
          if (empty) begin
            set_underflow = 1'b1;
            flush         = 1'b1;
            state_next    = RESYNC;
          end else if (head_sof && (cnt_reg != '0)) begin
            flush      = 1'b1;
            state_next = RESYNC;
          end else begin
            pop      = 1'b1;
            rgb_next = head[23:0];
            cnt_inc  = 1'b1;
            if (cnt_reg == CW'(PIX_TOTAL - 1)) state_next = WAIT_FRAME;
          end
        end
      end

      default: begin
        state_next = RESYNC;
        flush      = 1'b1;
      end
    endcase

    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    if (state_reg != RESYNC) begin
      in_ready = !full || pop;
      push     = in_valid && in_ready && !flush;
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state_reg     <= RESYNC;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      cnt_reg       <= '0;
      rgb_reg       <= '0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        level_reg <= level_reg + LW'(push) - LW'(pop);
      end
      if (cnt_clr)      cnt_reg <= '0;
      else if (cnt_inc) cnt_reg <= cnt_reg + CW'(1);
      if (rgb_load)      rgb_reg       <= rgb_next;
      if (set_underflow) underflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (push) mem[wr_ptr_reg] <= {in_sof, in_data};
  end

  assign rgb_out   = rgb_reg;
  assign underflow = underflow_reg;
  assign resync    = (state_reg == RESYNC);
  assign level     = level_reg;

endmodule
